// File: rtl/noc_rr_merge_arbiter.sv
// N-to-1 round-robin merge arbiter for NoC packets with a one-entry registered
// output stage, winning-source sideband and a wrapping accepted-packet counter.
module noc_rr_merge_arbiter #(
  parameter int N  = 4,
  parameter int W  = 9,
  parameter int SW = $clog2(N),
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  input  logic [N-1:0]   en_mask,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  input  logic           out_ready,
  output logic [CW-1:0]  pkt_count
);

  logic [W-1:0]  data_arr [N];
  logic [N-1:0]  req;
  logic          load_ok;
  logic          grant_any;
  logic          accept;
  logic [SW-1:0] winner;
  logic [SW:0]   pos_ext;
  logic [SW-1:0] pos;

  logic          out_valid_reg;
  logic [W-1:0]  out_data_reg;
  logic [SW-1:0] out_src_reg;
  logic [SW-1:0] rr_ptr_reg;
  logic [CW-1:0] pkt_count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign data_arr[gi] = in_data[gi*W +: W];
    end
  endgenerate

  // Scan offsets 0..N-1 from rr_ptr; the first eligible requester wins.
  always_comb begin
    req       = in_valid & en_mask;
    load_ok   = !out_valid_reg || out_ready;
    grant_any = 1'b0;
    winner    = '0;
    pos_ext   = '0;
    pos       = '0;
    for (int k = 0; k < N; k++) begin
      pos_ext = {1'b0, rr_ptr_reg} + (SW+1)'(k);
      if (pos_ext >= (SW+1)'(N)) begin
        pos_ext = pos_ext - (SW+1)'(N);
      end
      pos = pos_ext[SW-1:0];
      if (!grant_any && req[pos]) begin
        grant_any = 1'b1;
        winner    = pos;
      end
    end
  end

  // Gated by rst_n so no requester sees an accept while reset is held.
  assign in_ready = (rst_n && load_ok && grant_any) ? (N'(1) << winner) : '0;
  assign accept   = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      rr_ptr_reg    <= '0;
      pkt_count_reg <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= data_arr[winner];
      out_src_reg   <= winner;
      rr_ptr_reg    <= (winner == SW'(N-1)) ? '0 : winner + 1'b1;
      pkt_count_reg <= pkt_count_reg + 1'b1;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;
  assign pkt_count = pkt_count_reg;

endmodule

// File: tb/tb_noc_rr_merge_arbiter.sv
// Self-checking bench for noc_rr_merge_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a queue-free behavioural model.
module tb_noc_rr_merge_arbiter;
  localparam int N  = 4;
  localparam int W  = 9;
  localparam int SW = 2;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   en_mask;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_ready;
  logic [CW-1:0]  pkt_count;

  noc_rr_merge_arbiter #(.N(N), .W(W), .SW(SW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .en_mask(en_mask), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the output register and arbitration state
  int m_valid, m_data, m_src, m_ptr, m_cnt;
  int last_grant;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int grant_of(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0; m_cnt = 0; last_grant = -1;
  endtask

  // Called at a falling edge with inputs already applied; checks, advances the
  // model across the coming rising edge, and returns at the next falling edge.
  task automatic cycle();
    int w, best, d;
    logic [N-1:0] er;
    #1;
    w = -1; best = N;
    if (m_valid == 0 || out_ready) begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && en_mask[i]) begin
          d = (i - m_ptr + N) % N;
          if (d < best) begin best = d; w = i; end
        end
      end
    end
    er = (w >= 0) ? N'(1 << w) : '0;
    chk("in_ready", int'(in_ready), int'(er));
    chk("out_valid", int'(out_valid), m_valid);
    chk("out_data", int'(out_data), m_data);
    chk("out_src", int'(out_src), m_src);
    chk("pkt_count", int'(pkt_count), m_cnt);
    $display("cyc t=%0t valid=%b en=%b ordy=%b grant=%0d out_v=%0d src=%0d cnt=%0d",
             $time, in_valid, en_mask, out_ready, w, out_valid, out_src, pkt_count);
    if (w >= 0) begin
      m_data  = int'(in_data[w*W +: W]);
      m_src   = w;
      m_valid = 1;
      m_ptr   = (w + 1) % N;
      m_cnt   = (m_cnt + 1) % (1 << CW);
    end else if (m_valid != 0 && out_ready) begin
      m_valid = 0;
    end
    last_grant = w;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_pkt_count", int'(pkt_count), 0);
    chk("rst_out_src", int'(out_src), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int rot[6]  = '{0, 1, 2, 3, 0, 1};
    int msk[4]  = '{3, 1, 3, 1};
    int mskb[4] = '{2, 3, 0, 1};
    int held_data;
    rst_n = 1'b0; in_valid = '0; in_data = '0; en_mask = '1; out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single requester
    in_valid = 4'b0100; in_data[2*W +: W] = 9'h1A5;
    #1 chk("single_rdy", int'(in_ready), 4'b0100);
    cycle();
    in_valid = '0;
    #1;
    chk("single_ov", int'(out_valid), 1);
    chk("single_od", int'(out_data), 9'h1A5);
    chk("single_src", int'(out_src), 2);
    chk("single_cnt", int'(pkt_count), 1);
    cycle();

    // Full rotation from rr_ptr=0
    do_reset();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(9'h100 + i * 9'h11);
    in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rot_grant", grant_of(in_ready), rot[k]);
      cycle();
    end

    // Backpressure holding src 1
    out_ready = 1'b0;
    held_data = int'(out_data);
    #1 chk("bp_cnt", int'(pkt_count), 6);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rdy", int'(in_ready), 0);
      chk("bp_src", int'(out_src), 1);
      chk("bp_data", int'(out_data), held_data);
      cycle();
    end
    out_ready = 1'b1;
    #1 chk("bp_release", int'(in_ready), 4'b0100);
    cycle();

    // Masking, then re-enable
    en_mask = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1 chk("mask_grant", grant_of(in_ready), msk[k]);
      cycle();
    end
    en_mask = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1 chk("unmask_grant", grant_of(in_ready), mskb[k]);
      cycle();
    end

    // Counter wrap with CW=4
    do_reset();
    in_valid = 4'b0001;
    for (int k = 1; k <= 17; k++) begin
      cycle();
      if (k == 15) begin #1 chk("wrap15", int'(pkt_count), 15); end
      if (k == 16) begin #1 chk("wrap16", int'(pkt_count), 0); end
      if (k == 17) begin #1 chk("wrap17", int'(pkt_count), 1); end
    end

    // Reset asserted mid-stall
    in_valid = '0; out_ready = 1'b0;
    cycle();
    in_valid = 4'b1111;
    #1 chk("stall_ov", int'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ov", int'(out_valid), 0);
    chk("arst_cnt", int'(pkt_count), 0);
    chk("arst_rdy", int'(in_ready), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1 chk("arst_first", grant_of(in_ready), 0);
    cycle();

    // Randomized traffic respecting the hold-until-transfer rule
    for (int c = 0; c < 2000; c++) begin
      if (last_grant >= 0) in_valid[last_grant] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] && $urandom_range(1, 0) == 1) begin
          in_valid[i] = 1'b1;
          in_data[i*W +: W] = W'($urandom);
        end
      end
      if ($urandom_range(15, 0) == 0) en_mask = N'($urandom);
      out_ready = ($urandom_range(3, 0) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_rr_merge_arbiter.md
Name: noc_rr_merge_arbiter

Overview:
- Clocked N-input to 1-output merge arbiter for 9-bit NoC packets. Bits [8:5] are the destination address; bits [4:0] are the payload.
- Sits upstream of a decoder leaf: it shares a single router input channel between several requesters (local cores / neighbouring links).
- Uses work-conserving round-robin arbitration with a one-entry registered output stage.
- Reports the winning source on a sideband, mirroring the decoder's select channel.

Parameters:
- N, 4, number of requesting input channels (2..8).
- W, 9, packet width in bits; bits [W-1:W-4] are the address.
- SW, $clog2(N), width of the source-index sideband.
- CW, 16, width of the accepted-packet counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  per-requester packet valid.
- in_data  input  N*W  packed packets; requester i occupies [i*W +: W].
- in_ready  output  N  per-requester accept; at most one bit high per cycle.
- en_mask  input  N  requester enable; a 0 excludes that requester from arbitration.
- out_valid  output  1  output register holds a packet.
- out_data  output  W  registered packet.
- out_src  output  SW  index of the requester that supplied out_data.
- out_ready  input  1  downstream accept.
- pkt_count  output  CW  number of packets accepted into the output register, wrapping.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, pkt_count=0, rr_ptr=0. in_ready=0 while rst_n=0.
- Transfer rule: a transfer occurs on a rising edge when valid&&ready are both high on that channel. Producers hold valid and data stable until the transfer.
- Eligible set: req = in_valid & en_mask.
- Output state:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - load_ok = !out_valid || out_ready. The output register may load in the same cycle it drains, so throughput is one packet per cycle.
- Arbitration (combinational):
  - When load_ok and req!=0, the winner is the first set bit of req scanning from rr_ptr upward, modulo N.
  - in_ready[winner]=1; all other in_ready bits are 0.
  - If load_ok=0 or req=0, in_ready is all zeros.
- On accept (any in_ready bit high):
  - out_data <= in_data[winner]
  - out_src <= winner
  - out_valid <= 1
  - rr_ptr <= (winner+1) mod N
  - pkt_count <= pkt_count+1, wrapping from 2^CW-1 to 0
- Drain only (out_valid && out_ready && no accept): out_valid <= 0. out_data and out_src hold their last values.
- Stall (out_valid && !out_ready): out_data and out_src are stable. in_ready is all zero. rr_ptr is unchanged.
- Idle cycles (req=0) do not move rr_ptr.
- Latency: a packet accepted at edge k is visible on out_* after edge k. Minimum in-to-out latency is 1 cycle.
- Fairness: with all N requesters continuously valid and out_ready=1, grants cycle 0,1,..,N-1,0. Any continuously eligible requester is served within N accepts.
- en_mask deasserted while a requester is valid: that requester's in_ready stays 0 and its packet is held upstream, not dropped. Re-enabling restores eligibility with no state reset.
- in_valid dropped without a transfer is a protocol violation. The block behaves as if the request was withdrawn; no packet is recorded.
- rst_n asserted mid-stall: the held packet is discarded and outputs return to reset values immediately (asynchronously).
- The block never alters packet bits, and address bits are not interpreted here.

Test Plan:
- Single requester: in_valid=4'b0100, in_data[2]=9'h1A5, out_ready=1 -> in_ready=4'b0100 for one cycle; next cycle out_valid=1, out_data=9'h1A5, out_src=2, pkt_count=1.
- All four valid continuously, out_ready=1, rr_ptr=0 -> out_src sequence 0,1,2,3,0,1 on consecutive cycles; one in_ready bit high per cycle; pkt_count=6 after 6 cycles.
- Backpressure: out_valid=1 with out_src=1 and out_ready=0 for 5 cycles while in_valid=4'b1111 -> in_ready=0, and out_data/out_src unchanged. When out_ready=1, the next grant goes to requester 2 in the same cycle.
- Masking: in_valid=4'b1111, en_mask=4'b1010 -> grants alternate 1,3,1,3. Setting en_mask=4'b1111 then inserts 0 and 2 per round-robin order.
- Counter wrap with CW=4: 17 accepts -> pkt_count reads 15 after 15 accepts, 0 after 16, and 1 after 17.
- Reset mid-stall: out_valid=1, out_ready=0, then rst_n=0 asynchronously -> out_valid=0, pkt_count=0, in_ready=0 immediately. After release, the first grant with in_valid=4'b1111 goes to requester 0.
